// File: rtl/isdu_control.sv
// LC-3 multi-cycle control sequencer: fetch/decode/execute Moore FSM.
// Define ISDU_PAUSE_IR_EN to add IR-on-LED debug pause states after fetch.
module isdu_control #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    typedef enum logic [4:0] {
        HALTED, S18, S33, S35, S32,
        S01, S05, S09, S06, S25, S27,
        S07, S23, S16, S00, S22, S12,
        S04, S21, S13, S13B
`ifdef ISDU_PAUSE_IR_EN
        , PIR1, PIR2
`endif
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       first_q;
    logic       cnt_last;

    // JSRR is not supported, so IR[11] has no effect
    logic unused_ir11;
    assign unused_ir11 = IR_11;

    assign cnt_last = (cnt_q == 3'(MEM_WAIT - 1));

    // State, memory wait counter and state-entry flag
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= HALTED;
            cnt_q   <= '0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= (state_d != state_q);
        end
    end

    // Next-state decode and per-state datapath controls
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b00;
        ALUK       = 2'b00;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;
        unique case (state_q)
            HALTED: begin
                if (Run) state_d = S18;
            end
            S18: begin
                GatePC  = 1'b1;
                LD_MAR  = 1'b1;
                LD_PC   = 1'b1;
                state_d = S33;
            end
            S33: begin
                Mem_OE = 1'b0;
                LD_MDR = 1'b1;
                if (cnt_last) state_d = S35;
                else          cnt_d   = cnt_q + 3'd1;
            end
            S35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
`ifdef ISDU_PAUSE_IR_EN
                state_d = PIR1;
`else
                state_d = S32;
`endif
            end
`ifdef ISDU_PAUSE_IR_EN
            PIR1: begin
                LD_LED = first_q;
                if (Continue) state_d = PIR2;
            end
            PIR2: begin
                if (!Continue) state_d = S32;
            end
`endif
            S32: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    4'b0001: state_d = S01;
                    4'b0101: state_d = S05;
                    4'b1001: state_d = S09;
                    4'b0110: state_d = S06;
                    4'b0111: state_d = S07;
                    4'b0000: state_d = S00;
                    4'b1100: state_d = S12;
                    4'b0100: state_d = S04;
                    4'b1101: state_d = S13;
                    default: state_d = S18;
                endcase
            end
            S01, S05: begin
                SR1MUX  = 1'b1;
                SR2MUX  = IR_5;
                ALUK    = (state_q == S05) ? 2'b01 : 2'b00;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_d = S18;
            end
            S09: begin
                SR1MUX  = 1'b1;
                ALUK    = 2'b11;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_d = S18;
            end
            S06, S07: begin
                ADDR1MUX   = 1'b1;
                SR1MUX     = 1'b1;
                ADDR2MUX   = 2'b01;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                state_d    = (state_q == S06) ? S25 : S23;
            end
            S25: begin
                Mem_OE = 1'b0;
                LD_MDR = 1'b1;
                if (cnt_last) state_d = S27;
                else          cnt_d   = cnt_q + 3'd1;
            end
            S27: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_d = S18;
            end
            S23: begin
                ALUK    = 2'b10;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
                state_d = S16;
            end
            S16: begin
                Mem_WE = 1'b0;
                if (cnt_last) state_d = S18;
                else          cnt_d   = cnt_q + 3'd1;
            end
            S00: begin
                state_d = BEN ? S22 : S18;
            end
            S22: begin
                ADDR2MUX = 2'b10;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
                state_d  = S18;
            end
            S12: begin
                SR1MUX  = 1'b1;
                ALUK    = 2'b10;
                GateALU = 1'b1;
                PCMUX   = 2'b01;
                LD_PC   = 1'b1;
                state_d = S18;
            end
            S04: begin
                GatePC  = 1'b1;
                DRMUX   = 1'b1;
                LD_REG  = 1'b1;
                state_d = S21;
            end
            S21: begin
                ADDR2MUX = 2'b11;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
                state_d  = S18;
            end
            S13: begin
                LD_LED = first_q;
                if (Continue) state_d = S13B;
            end
            S13B: begin
                if (!Continue) state_d = S18;
            end
            default: state_d = HALTED;
        endcase
    end

    // Only one source may drive the shared bus in any cycle
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            assert ($onehot0({GatePC, GateMDR, GateALU, GateMARMUX}))
            else $error("isdu_control: bus contention");
        end
    end

endmodule

// File: tb/tb_isdu_control.sv
// Scoreboard bench for isdu_control: expected control words per cycle.
// Stimulus for the next edge travels with each expected entry.
module tb_isdu_control;

    localparam int W = 2;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Run = 1'b0;
    logic       Continue = 1'b0;
    logic [3:0] Opcode = 4'h0;
    logic       IR_5 = 1'b0;
    logic       IR_11 = 1'b0;
    logic       BEN = 1'b0;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE;

    isdu_control #(.MEM_WAIT(W)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR),
        .LD_BEN(LD_BEN), .LD_CC(LD_CC), .LD_REG(LD_REG),
        .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
        .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .DRMUX(DRMUX),
        .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
        .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    always #5 Clk = ~Clk;

    logic [23:0] obs;
    assign obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
                  LD_LED, GatePC, GateMDR, GateALU, GateMARMUX, PCMUX,
                  DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
                  Mem_OE, Mem_WE};

    typedef enum {
        T_HALT, T_S18, T_S33, T_S35, T_PIR1, T_PIR2, T_S32,
        T_S01, T_S05, T_S09, T_S06, T_S25, T_S27, T_S07, T_S23,
        T_S16, T_S00, T_S22, T_S12, T_S04, T_S21, T_S13, T_S13B
    } sym_e;

    typedef struct {
        logic [23:0] exp;
        string       tag;
        logic        cont;
        logic        run;
        logic        rst;
        logic [3:0]  op;
        logic        ir5;
        logic        ben;
    } ent_t;

    ent_t       q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         seq = 0;
    sym_e       last_s = T_HALT;
    logic [3:0] cur_op = 4'h0;
    logic       cur_ir5 = 1'b0;
    logic       cur_ben = 1'b0;

    task automatic chk(input string tag, input logic [23:0] got,
                       input logic [23:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_of(sym_e s, bit first, bit ir5);
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic g_pc, g_mdr, g_alu, g_mm, drmux, sr1, sr2, a1, oe, we;
        logic [1:0] pcmux, a2, aluk;
        {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led} = '0;
        {g_pc, g_mdr, g_alu, g_mm, drmux, sr1, sr2, a1} = '0;
        pcmux = 2'b00;
        a2    = 2'b00;
        aluk  = 2'b00;
        oe    = 1'b1;
        we    = 1'b1;
        case (s)
            T_S18: begin g_pc = 1; ld_mar = 1; ld_pc = 1; end
            T_S33, T_S25: begin oe = 0; ld_mdr = 1; end
            T_S35: begin g_mdr = 1; ld_ir = 1; end
            T_PIR1, T_S13: ld_led = first;
            T_S32: ld_ben = 1;
            T_S01: begin
                sr1 = 1; sr2 = ir5; g_alu = 1; ld_reg = 1; ld_cc = 1;
            end
            T_S05: begin
                sr1 = 1; sr2 = ir5; aluk = 2'b01; g_alu = 1;
                ld_reg = 1; ld_cc = 1;
            end
            T_S09: begin
                sr1 = 1; aluk = 2'b11; g_alu = 1; ld_reg = 1; ld_cc = 1;
            end
            T_S06, T_S07: begin
                a1 = 1; sr1 = 1; a2 = 2'b01; g_mm = 1; ld_mar = 1;
            end
            T_S27: begin g_mdr = 1; ld_reg = 1; ld_cc = 1; end
            T_S23: begin aluk = 2'b10; g_alu = 1; ld_mdr = 1; end
            T_S16: we = 0;
            T_S22: begin a2 = 2'b10; pcmux = 2'b10; ld_pc = 1; end
            T_S12: begin
                sr1 = 1; aluk = 2'b10; g_alu = 1; pcmux = 2'b01; ld_pc = 1;
            end
            T_S04: begin g_pc = 1; drmux = 1; ld_reg = 1; end
            T_S21: begin a2 = 2'b11; pcmux = 2'b10; ld_pc = 1; end
            default: ;
        endcase
        return {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                g_pc, g_mdr, g_alu, g_mm, pcmux, drmux, sr1, sr2, a1, a2,
                aluk, oe, we};
    endfunction

    task automatic push(input sym_e s, input bit c = 0, input bit r = 0,
                        input bit rs = 0);
        ent_t e;
        e.exp  = exp_of(s, s != last_s, cur_ir5);
        e.tag  = $sformatf("%s@%0d", s.name(), seq);
        e.cont = c;
        e.run  = r;
        e.rst  = rs;
        e.op   = cur_op;
        e.ir5  = cur_ir5;
        e.ben  = cur_ben;
        last_s = s;
        seq++;
        q.push_back(e);
    endtask

    task automatic drain();
        ent_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge Clk);
            chk(e.tag, obs, e.exp);
            Continue = e.cont;
            Run      = e.run;
            Reset    = e.rst;
            Opcode   = e.op;
            IR_5     = e.ir5;
            BEN      = e.ben;
        end
    endtask

    task automatic instr(input logic [3:0] op, input bit ir5,
                         input bit ben, input bit cont_early);
        cur_op  = op;
        cur_ir5 = ir5;
        cur_ben = ben;
        push(T_S18);
        repeat (W) push(T_S33);
        push(T_S35);
`ifdef ISDU_PAUSE_IR_EN
        push(T_PIR1);
        push(T_PIR1, 1);
        push(T_PIR2, 1);
        push(T_PIR2, 0);
`endif
        push(T_S32);
        case (op)
            4'b0001: push(T_S01);
            4'b0101: push(T_S05);
            4'b1001: push(T_S09);
            4'b0110: begin
                push(T_S06);
                repeat (W) push(T_S25);
                push(T_S27);
            end
            4'b0111: begin
                push(T_S07);
                push(T_S23);
                repeat (W) push(T_S16);
            end
            4'b0000: begin
                push(T_S00);
                if (ben) push(T_S22);
            end
            4'b1100: push(T_S12);
            4'b0100: begin
                push(T_S04);
                push(T_S21);
            end
            4'b1101: begin
                if (cont_early) begin
                    push(T_S13, 1);
                    repeat (4) push(T_S13B, 1);
                    push(T_S13B, 0);
                end else begin
                    push(T_S13, 0);
                    push(T_S13, 0);
                    push(T_S13, 1);
                    push(T_S13B, 1);
                    push(T_S13B, 0);
                end
            end
            default: ;
        endcase
        drain();
    endtask

    initial begin
        push(T_HALT, 0, 0, 1);
        push(T_HALT);
        push(T_HALT, 0, 1);
        push(T_S18);
        push(T_S33, 0, 0, 1);
        push(T_HALT);
        push(T_HALT, 0, 1);
        drain();
        instr(4'b0001, 1, 0, 0);
        instr(4'b0001, 0, 0, 0);
        instr(4'b0101, 1, 0, 0);
        instr(4'b1001, 0, 0, 0);
        instr(4'b0110, 0, 0, 0);
        instr(4'b0111, 0, 0, 0);
        instr(4'b0000, 0, 0, 0);
        instr(4'b0000, 0, 1, 0);
        instr(4'b1100, 0, 0, 0);
        instr(4'b0100, 0, 0, 0);
        instr(4'b1101, 0, 0, 1);
        instr(4'b1101, 0, 0, 0);
        instr(4'b1111, 0, 0, 0);
        instr(4'b0011, 1, 1, 0);
        instr(4'b0101, 0, 1, 0);
        push(T_S18);
        drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
